// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one SRAM-like memory port between the icache and
// dcache controllers. The owning master keeps the port until its requests stop
// and all of its outstanding transactions have returned data.
// Build option: CACHE_ARB_RR_EN selects round-robin tie-breaking. When it is
// not defined, the dcache wins ties.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_addr_ok,
  output logic              i_data_ok,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_addr_ok,
  output logic              d_data_ok,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

`ifdef CACHE_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic             last_d_q;      // 1: dcache held the most recent grant
  logic             owner_req;
  logic             accept;
  logic             retire;
  logic             release_grant;
  logic             pick_d;

  assign owner   = state_q;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // Memory port mux and handshake routing, driven purely by the current owner.
  always_comb begin
    owner_req = 1'b0;
    mem_wr    = 1'b0;
    mem_size  = 2'b00;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      GNT_I: begin
        owner_req = i_req;
        mem_size  = 2'b11;
        mem_addr  = i_addr;
      end
      GNT_D: begin
        owner_req = d_req;
        mem_wr    = d_wr;
        mem_size  = d_size;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
      default: ;
    endcase
    mem_req   = owner_req & (outst_q < CNT_W'(MAX_OUTST));
    i_addr_ok = (state_q == GNT_I) & mem_req & mem_addr_ok;
    d_addr_ok = (state_q == GNT_D) & mem_req & mem_addr_ok;
    i_data_ok = (state_q == GNT_I) & mem_data_ok;
    d_data_ok = (state_q == GNT_D) & mem_data_ok;
  end

  // Outstanding-transaction count; a data beat with nothing outstanding is ignored.
  always_comb begin
    accept  = mem_req & mem_addr_ok;
    retire  = mem_data_ok & (outst_q != '0);
    outst_d = outst_q;
    if (accept && !retire) begin
      outst_d = outst_q + CNT_W'(1);
    end else if (!accept && retire) begin
      outst_d = outst_q - CNT_W'(1);
    end
    release_grant = ~owner_req & (outst_d == '0);
  end

  // Grant selection: tie-break, hold while busy, direct hand-over on release.
  always_comb begin
    if (RR_EN && i_req && d_req) begin
      pick_d = ~last_d_q;
    end else begin
      pick_d = d_req;
    end
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) state_d = pick_d ? GNT_D : GNT_I;
      end
      GNT_I: begin
        if (release_grant) state_d = d_req ? GNT_D : IDLE;
      end
      GNT_D: begin
        if (release_grant) state_d = i_req ? GNT_I : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Owner, outstanding count and last-grant history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      outst_q  <= '0;
      last_d_q <= 1'b1;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      if (state_d != state_q && state_d != IDLE) begin
        last_d_q <= (state_d == GNT_D);
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Testbench for cache_mem_arbiter: directed arbitration/boundary scenarios plus
// randomized traffic against a transaction-level memory and master model.
module tb_cache_mem_arbiter;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MAX_OUTST = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_req, i_addr_ok, i_data_ok;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req, d_wr, d_addr_ok, d_data_ok;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic              mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]        mem_size, owner;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
    int unsigned gap;
  } job_t;

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
  } exp_t;

  job_t        i_jobs[$], d_jobs[$];
  exp_t        i_exp[$], d_exp[$];
  logic [31:0] pend[$];
  logic [31:0] mem_arr[logic [31:0]];
  logic [31:0] ref_arr[logic [31:0]];
  int unsigned i_gap, d_gap;
  int          aok_pct, dok_pct;
  bit          force_dok, rst_drv;
  int          checks, failures;
  int          seen_idok, seen_ddok, seen_acc;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hA5C3_5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, req, $time);
    end
  endtask

  // One clock of environment: masters present their head job, memory answers
  // in order, then handshakes are observed just after the falling edge.
  task automatic tick();
    bit          dok_now, acc_i, acc_d, took_i, took_d;
    int          model_outst;
    job_t        j;
    exp_t        e;
    @(negedge clk);
    reset = rst_drv;
    i_req = (i_jobs.size() > 0) && (i_gap == 0);
    i_addr = i_req ? i_jobs[0].addr : '0;
    d_req = (d_jobs.size() > 0) && (d_gap == 0);
    d_wr    = d_req ? d_jobs[0].wr    : 1'b0;
    d_size  = d_req ? d_jobs[0].size  : 2'b00;
    d_addr  = d_req ? d_jobs[0].addr  : '0;
    d_wdata = d_req ? d_jobs[0].wdata : '0;
    mem_addr_ok = (int'($urandom_range(99)) < aok_pct);
    dok_now = 1'b0;
    if (force_dok) begin
      mem_data_ok = 1'b1;
      mem_rdata   = $urandom;
    end else if (pend.size() > 0 && int'($urandom_range(99)) < dok_pct) begin
      mem_data_ok = 1'b1;
      mem_rdata   = pend.pop_front();
      dok_now     = 1'b1;
    end else begin
      mem_data_ok = 1'b0;
      mem_rdata   = $urandom;
    end
    #1;
    acc_i = 1'b0; acc_d = 1'b0; took_i = 1'b0; took_d = 1'b0;
    if (i_data_ok) seen_idok++;
    if (d_data_ok) seen_ddok++;
    if (!rst_drv) begin
      model_outst = pend.size() + (dok_now ? 1 : 0);
      if (mem_req) chk("outst_limit", (model_outst < int'(MAX_OUTST)) ? 32'd1 : 32'd0, 32'd1);
      if (mem_req && mem_addr_ok) begin
        seen_acc++;
        if (mem_wr) begin
          mem_arr[mem_addr] = mem_wdata;
          pend.push_back($urandom);
        end else begin
          pend.push_back(mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : init_word(mem_addr));
        end
        chk("addr_ok_onehot", 32'(int'(i_addr_ok) + int'(d_addr_ok)), 32'd1);
        acc_i = i_addr_ok && !d_addr_ok;
        acc_d = d_addr_ok && !i_addr_ok;
      end else begin
        chk("addr_ok_without_handshake", {30'd0, i_addr_ok, d_addr_ok}, 32'd0);
      end
      if (acc_i) begin
        chk("i_addr_ok_with_req", 32'(i_req), 32'd1);
        if (i_jobs.size() > 0) begin
          j = i_jobs.pop_front();
          took_i = 1'b1;
          chk("i_mem_addr", mem_addr, j.addr);
          chk("i_mem_wr", 32'(mem_wr), 32'd0);
          chk("i_mem_size", 32'(mem_size), 32'd3);
          chk("i_mem_wdata", mem_wdata, 32'd0);
          e.wr = 1'b0;
          e.rdata = ref_arr.exists(j.addr) ? ref_arr[j.addr] : init_word(j.addr);
          i_exp.push_back(e);
          i_gap = j.gap;
        end
      end
      if (acc_d) begin
        chk("d_addr_ok_with_req", 32'(d_req), 32'd1);
        if (d_jobs.size() > 0) begin
          j = d_jobs.pop_front();
          took_d = 1'b1;
          chk("d_mem_addr", mem_addr, j.addr);
          chk("d_mem_wr", 32'(mem_wr), 32'(j.wr));
          chk("d_mem_size", 32'(mem_size), 32'(j.size));
          chk("d_mem_wdata", mem_wdata, j.wdata);
          e.wr = j.wr;
          if (j.wr) begin
            ref_arr[j.addr] = j.wdata;
            e.rdata = '0;
          end else begin
            e.rdata = ref_arr.exists(j.addr) ? ref_arr[j.addr] : init_word(j.addr);
          end
          d_exp.push_back(e);
          d_gap = j.gap;
        end
      end
    end
    if (!took_i && i_gap > 0) i_gap--;
    if (!took_d && d_gap > 0) d_gap--;
  endtask

  task automatic push_i(input logic [31:0] base, input int unsigned beats, input bit rnd_gap);
    job_t j;
    for (int unsigned b = 0; b < beats; b++) begin
      j.addr  = base + 32'(4 * b);
      j.wr    = 1'b0;
      j.size  = 2'b11;
      j.wdata = '0;
      j.gap   = rnd_gap ? $urandom_range(2) : 0;
      i_jobs.push_back(j);
    end
  endtask

  task automatic push_d(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                        input logic [31:0] wdata, input int unsigned gap);
    job_t j;
    j.addr = addr; j.wr = wr; j.size = size; j.wdata = wdata; j.gap = gap;
    d_jobs.push_back(j);
  endtask

  task automatic do_reset();
    i_jobs.delete(); d_jobs.delete();
    i_gap = 0; d_gap = 0;
    aok_pct = 0; dok_pct = 0; force_dok = 1'b0;
    rst_drv = 1'b1;
    tick();
    tick();
    pend.delete(); i_exp.delete(); d_exp.delete();
    rst_drv = 1'b0;
  endtask

  task automatic run_while_owner(input logic [1:0] o, input int bound, input string name);
    int n;
    n = 0;
    while (owner == o && n < bound) begin
      tick();
      n++;
    end
    chk(name, (owner == o) ? 32'd1 : 32'd0, 32'd0);
  endtask

  // From IDLE with stalled data: count addresses accepted before mem_req drops.
  task automatic fill_check(input string name);
    seen_acc = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (seen_acc > 0 && !mem_req) break;
    end
    chk(name, 32'(seen_acc), 32'(MAX_OUTST));
  endtask

  // Scoreboard monitor: every data_ok pops the owning master's expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (i_data_ok) begin
        chk("i_data_ok_expected", (i_exp.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (i_exp.size() > 0) begin
          e = i_exp.pop_front();
          chk("i_rdata", i_rdata, e.rdata);
        end
      end
      if (d_data_ok) begin
        chk("d_data_ok_expected", (d_exp.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (d_exp.size() > 0) begin
          e = d_exp.pop_front();
          if (!e.wr) chk("d_rdata", d_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] first_g, second_g;
    reset = 1'b1; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_wr = 1'b0; d_size = 2'b00; d_addr = '0; d_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    checks = 0; failures = 0; seen_idok = 0; seen_ddok = 0; seen_acc = 0;
    rst_drv = 1'b1; force_dok = 1'b0; i_gap = 0; d_gap = 0; aok_pct = 0; dok_pct = 0;

    do_reset();
    chk("reset_owner", 32'(owner), 32'd0);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_oks", {28'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 32'd0);

    // Icache 4-beat read, one arbitration cycle, back to IDLE afterwards.
    push_i(32'h1000, 4, 1'b0);
    aok_pct = 100; dok_pct = 100; seen_idok = 0; seen_ddok = 0;
    tick();
    chk("t1_arb_owner", 32'(owner), 32'd0);
    chk("t1_arb_mem_req", 32'(mem_req), 32'd0);
    tick();
    chk("t1_grant_owner", 32'(owner), 32'd1);
    chk("t1_grant_mem_req", 32'(mem_req), 32'd1);
    run_while_owner(2'b01, 50, "t1_release_timeout");
    chk("t1_idle_after", 32'(owner), 32'd0);
    chk("t1_i_data_ok_count", 32'(seen_idok), 32'd4);
    chk("t1_d_data_ok_count", 32'(seen_ddok), 32'd0);

    // Simultaneous requests: tie-break, then direct hand-over.
    do_reset();
`ifdef CACHE_ARB_RR_EN
    first_g = 2'b01; second_g = 2'b10;
`else
    first_g = 2'b10; second_g = 2'b01;
`endif
    push_i(32'h1100, 4, 1'b0);
    for (int b = 0; b < 4; b++) push_d(32'h3000 + 32'(4 * b), 1'b0, 2'b11, '0, 0);
    aok_pct = 100; dok_pct = 100; seen_idok = 0; seen_ddok = 0;
    tick();
    chk("t2_arb_owner", 32'(owner), 32'd0);
    tick();
    chk("t2_first_grant", 32'(owner), 32'(first_g));
    run_while_owner(first_g, 100, "t2_first_release_timeout");
    chk("t2_handover_no_idle", 32'(owner), 32'(second_g));
    chk("t2_first_beats", 32'((first_g == 2'b10) ? seen_ddok : seen_idok), 32'd4);
    chk("t2_other_quiet", 32'((first_g == 2'b10) ? seen_idok : seen_ddok), 32'd0);
    seen_idok = 0; seen_ddok = 0;
    run_while_owner(second_g, 100, "t2_second_release_timeout");
    chk("t2_idle_after", 32'(owner), 32'd0);
    chk("t2_second_beats", 32'((second_g == 2'b10) ? seen_ddok : seen_idok), 32'd4);

    // Outstanding limit: stall data, mem_req drops and re-arms after one beat.
    do_reset();
    push_i(32'h1200, 8, 1'b0);
    aok_pct = 100; dok_pct = 0;
    fill_check("t4_fill_count");
    tick();
    chk("t4_stalled_mem_req", 32'(mem_req), 32'd0);
    dok_pct = 100;
    tick();
    chk("t4_first_dok_cycle", 32'(mem_req), 32'd0);
    dok_pct = 0;
    tick();
    chk("t4_reassert", 32'(mem_req), 32'd1);
    dok_pct = 100;
    run_while_owner(2'b01, 100, "t4_release_timeout");
    chk("t4_idle_after", 32'(owner), 32'd0);

    // Single dcache word write.
    do_reset();
    push_d(32'h2004, 1'b1, 2'b10, 32'hDEAD_BEEF, 0);
    aok_pct = 100; dok_pct = 100; seen_idok = 0; seen_ddok = 0;
    tick();
    tick();
    chk("t5_owner", 32'(owner), 32'd2);
    chk("t5_mem_wr", 32'(mem_wr), 32'd1);
    chk("t5_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("t5_mem_size", 32'(mem_size), 32'd2);
    run_while_owner(2'b10, 20, "t5_release_timeout");
    chk("t5_idle_after", 32'(owner), 32'd0);
    chk("t5_d_data_ok_count", 32'(seen_ddok), 32'd1);
    chk("t5_i_data_ok_count", 32'(seen_idok), 32'd0);

    // Reset with three transactions outstanding; late data must be dropped.
    do_reset();
    push_i(32'h1300, 6, 1'b0);
    aok_pct = 100; dok_pct = 0; seen_acc = 0;
    tick();
    for (int n = 0; n < 3; n++) tick();
    chk("t6_outst_before_reset", 32'(seen_acc), 32'd3);
    i_jobs.delete(); aok_pct = 0; rst_drv = 1'b1;
    tick();
    rst_drv = 1'b0;
    pend.delete(); i_exp.delete(); d_exp.delete();
    tick();
    chk("t6_owner_after_reset", 32'(owner), 32'd0);
    seen_idok = 0; seen_ddok = 0; force_dok = 1'b1;
    tick();
    force_dok = 1'b0;
    chk("t6_late_dok_dropped", 32'(seen_idok + seen_ddok), 32'd0);
    push_i(32'h1400, 6, 1'b0);
    aok_pct = 100; dok_pct = 0;
    fill_check("t6_outst_cleared");
    dok_pct = 100;
    run_while_owner(2'b01, 100, "t6_release_timeout");

    // Randomized mixed traffic over a small shared address pool.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 250 == 0) begin
        aok_pct = 30 + int'($urandom_range(70));
        dok_pct = 30 + int'($urandom_range(70));
      end
      if (i_jobs.size() < 6 && $urandom_range(99) < 8)
        push_i(32'h100 + 32'(16 * $urandom_range(7)), 1 + $urandom_range(3), 1'b1);
      if (d_jobs.size() < 6 && $urandom_range(99) < 8) begin
        for (int unsigned b = 0; b <= $urandom_range(3); b++)
          push_d(32'h100 + 32'(4 * $urandom_range(31)), 1'($urandom_range(1)),
                 2'($urandom_range(3)), $urandom, $urandom_range(2));
      end
      tick();
    end
    aok_pct = 100; dok_pct = 100;
    for (int n = 0; n < 500; n++) begin
      if (i_jobs.size() == 0 && d_jobs.size() == 0 && pend.size() == 0 &&
          i_exp.size() == 0 && d_exp.size() == 0 && owner == 2'b00) break;
      tick();
    end
    chk("random_drained", (i_jobs.size() == 0 && d_jobs.size() == 0 && pend.size() == 0 &&
                           i_exp.size() == 0 && d_exp.size() == 0 && owner == 2'b00) ? 32'd1 : 32'd0,
        32'd1);
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
